// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and instruction-handoff signals
// of the fetch stage. "master" is the fetch unit's view, "slave" is the
// environment's view (instruction memory plus datapath).
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rvalid, imem_rdata, redirect_en, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_rvalid, imem_rdata, redirect_en, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues one instruction-memory request at a
// time and buffers returned words with their PCs in a small FIFO that feeds
// the datapath over valid/ready. Redirects flush the FIFO and turn any
// outstanding request into one whose response is discarded.
// Optional feature: define FETCH_STALL_CNT_EN to add the stall_cycles counter
// (cycles out of reset with no instruction available).
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter int              BUF_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic           clk,
  input  logic           reset,
  fetch_unit_if.master   bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]    stall_cycles
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  // IDLE: nothing outstanding; WAIT: outstanding, response kept;
  // DROP: outstanding, response discarded (request predates a redirect)
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] inst_mem_q [BUF_DEPTH];
  logic [XLEN-1:0] pc_mem_q   [BUF_DEPTH];

  logic            fifo_nonempty;
  logic            pop;
  logic            resp;
  logic            push;
  logic            issue;
  logic [CW-1:0]   occ_after;

  assign fifo_nonempty  = (count_q != '0);
  assign bus.inst_valid = fifo_nonempty;
  assign bus.inst       = fifo_nonempty ? inst_mem_q[rd_ptr_q] : '0;
  assign bus.inst_pc    = fifo_nonempty ? pc_mem_q[rd_ptr_q]   : '0;
  assign bus.imem_addr  = fpc_q;
  assign bus.imem_req   = issue;

  // State register plus fetch PC and FIFO bookkeeping; reset wins over everything
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      fpc_q    <= RESET_PC;
      req_pc_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage: entries are only meaningful while counted, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  // Output/decision logic: handshakes, response acceptance and the issue rule
  always_comb begin
    pop       = fifo_nonempty && bus.inst_ready;
    resp      = bus.imem_rvalid && (state_q != S_IDLE);
    push      = resp && (state_q == S_WAIT) && !bus.redirect_en;
    occ_after = count_q - CW'(pop) + CW'(push);
    issue     = reset && !bus.redirect_en
                && ((state_q == S_IDLE) || resp)
                && (occ_after < CW'(BUF_DEPTH));
  end

  // Next-state logic of the request FSM
  always_comb begin
    state_d = state_q;
    if (bus.redirect_en) begin
      if (state_q != S_IDLE) begin
        state_d = bus.imem_rvalid ? S_IDLE : S_DROP;
      end
    end else if (issue) begin
      state_d = S_WAIT;
    end else if (resp) begin
      state_d = S_IDLE;
    end
  end

  // Next fetch PC, request PC and FIFO pointers; a redirect flushes after any pop
  always_comb begin
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = occ_after;
    if (bus.redirect_en) begin
      fpc_d    = bus.redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (issue) begin
      fpc_d    = fpc_q + 1'b1;
      req_pc_d = fpc_q;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  assign stall_cycles = stall_q;

  // Saturating count of cycles with no instruction on offer
  always_comb begin
    stall_d = stall_q;
    if (!fifo_nonempty && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

endmodule
